// File: rtl/tcm_port_arbiter.sv
// tcm_port_arbiter
//   Shares one single-port, word-wide TCM SRAM between the core's instruction
//   fetch (I) and data (D) ports. The grant is decided combinationally and the
//   SRAM is enabled in the same cycle. The response is returned exactly one
//   cycle later. There is no response backpressure.
//
//   Contention policy:
//     default                  D has priority. A starved I request wins once
//                              starve_cnt reaches STARVE_LIMIT.
//     TCM_ARB_ROUND_ROBIN_EN   On contended cycles, the loser of the previous
//                              contended cycle wins.
//
//   Ports
//     clk_i, rst_i              clock and asynchronous active-low reset
//     i_rd_i, i_pc_i            fetch request
//     i_accept_o                fetch accepted this cycle
//     i_valid_o, i_error_o,
//     i_inst_o                  fetch response
//     d_addr_i, d_data_wr_i,
//     d_rd_i, d_wr_i,
//     d_req_tag_i               data request; non-zero d_wr_i makes it a write
//     d_accept_o                data request accepted this cycle
//     d_ack_o, d_error_o,
//     d_data_rd_o,
//     d_resp_tag_o              data response
//     sram_*                    single-port SRAM macro interface; read data
//                               arrives the cycle after sram_en_o
module tcm_port_arbiter #(
  parameter int MEM_WORDS    = 16384,
  parameter int AW           = 14,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_rd_i,
  input  logic [31:0]   i_pc_i,
  output logic          i_accept_o,
  output logic          i_valid_o,
  output logic          i_error_o,
  output logic [31:0]   i_inst_o,
  input  logic [31:0]   d_addr_i,
  input  logic [31:0]   d_data_wr_i,
  input  logic          d_rd_i,
  input  logic [3:0]    d_wr_i,
  input  logic [10:0]   d_req_tag_i,
  output logic          d_accept_o,
  output logic          d_ack_o,
  output logic          d_error_o,
  output logic [31:0]   d_data_rd_o,
  output logic [10:0]   d_resp_tag_o,
  output logic          sram_en_o,
  output logic [3:0]    sram_we_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [31:0]   sram_wdata_o,
  input  logic [31:0]   sram_rdata_i
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic          i_req, d_req, d_is_wr;
  logic          i_in_rng, d_in_rng;
  logic          grant_i, grant_d;
  logic          starve_hit;
  logic [SW-1:0] starve_cnt;

  // one-deep response pipeline
  logic          i_vld_q, i_err_q;
  logic          d_vld_q, d_err_q, d_wr_q;
  logic [10:0]   d_tag_q;

  // The low two address bits are byte offsets within a word. The SRAM
  // addresses words, so these bits are never used.
  logic          unused_addr_lsb;
  assign unused_addr_lsb = ^{i_pc_i[1:0], d_addr_i[1:0]};

  assign i_req      = i_rd_i;
  assign d_is_wr    = |d_wr_i;
  assign d_req      = d_rd_i | d_is_wr;
  assign i_in_rng   = ({2'b00, i_pc_i[31:2]}   < 32'(MEM_WORDS));
  assign d_in_rng   = ({2'b00, d_addr_i[31:2]} < 32'(MEM_WORDS));
  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));

`ifdef TCM_ARB_ROUND_ROBIN_EN
  // Records which port won the last contended cycle (1 = D). The reset value
  // of I makes D win the first contention.
  logic rr_last_d;

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i)              rr_last_d <= 1'b0;
    else if (i_req && d_req) rr_last_d <= grant_d;
`endif

  // Grants are forced low while reset is held. This keeps accept and the
  // SRAM strobes at 0 for the whole time reset is asserted.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (rst_i) begin
      if (i_req && d_req) begin
`ifdef TCM_ARB_ROUND_ROBIN_EN
        if (rr_last_d) grant_i = 1'b1;
        else           grant_d = 1'b1;
`else
        if (starve_hit) grant_i = 1'b1;
        else            grant_d = 1'b1;
`endif
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  assign i_accept_o = grant_i;
  assign d_accept_o = grant_d;

  // An out-of-range request is still accepted, but it never reaches the SRAM.
  always_comb begin
    sram_en_o    = 1'b0;
    sram_we_o    = 4'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    if (grant_d && d_in_rng) begin
      sram_en_o    = 1'b1;
      sram_we_o    = d_wr_i;
      sram_addr_o  = d_addr_i[AW+1:2];
      sram_wdata_o = d_data_wr_i;
    end else if (grant_i && i_in_rng) begin
      sram_en_o    = 1'b1;
      sram_addr_o  = i_pc_i[AW+1:2];
    end
  end

  // Counts consecutive cycles in which I requests and loses.
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i)                starve_cnt <= '0;
    else if (!i_req || grant_i) starve_cnt <= '0;
    else if (!starve_hit)      starve_cnt <= starve_cnt + SW'(1);

  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      i_vld_q <= 1'b0;
      i_err_q <= 1'b0;
      d_vld_q <= 1'b0;
      d_err_q <= 1'b0;
      d_wr_q  <= 1'b0;
      d_tag_q <= '0;
    end else begin
      i_vld_q <= grant_i;
      i_err_q <= grant_i & ~i_in_rng;
      d_vld_q <= grant_d;
      d_err_q <= grant_d & ~d_in_rng;
      d_wr_q  <= grant_d & d_is_wr;
      if (grant_d) d_tag_q <= d_req_tag_i;
    end

  assign i_valid_o    = i_vld_q;
  assign i_error_o    = i_err_q;
  assign i_inst_o     = (i_vld_q && !i_err_q) ? sram_rdata_i : 32'h0;
  assign d_ack_o      = d_vld_q;
  assign d_error_o    = d_err_q;
  assign d_data_rd_o  = (d_vld_q && !d_err_q && !d_wr_q) ? sram_rdata_i : 32'h0;
  assign d_resp_tag_o = d_tag_q;

endmodule
